// File: rtl/aurora_rx_link_monitor.sv
`default_nettype none
// ============================================================================
// aurora_rx_link_monitor : Aurora simplex RX sideband stretch, status, link FSM
// Revision 1.0
// ============================================================================
module aurora_rx_link_monitor #(
  parameter int LANES       = 1,
  parameter int STRETCH     = 4,
  parameter int CNT_W       = 16,
  parameter int UP_DEBOUNCE = 8
) (
  input  logic             user_clk_rx,
  input  logic             rx_system_reset_n,
  input  logic [LANES-1:0] aligned_in,
  input  logic [LANES-1:0] verify_in,
  input  logic [LANES-1:0] reset_in,
  output logic [LANES-1:0] rx_aligned,
  output logic [LANES-1:0] rx_verify,
  output logic [LANES-1:0] rx_reset,
  input  logic             hard_err_in,
  input  logic             soft_err_in,
  input  logic             frame_err_in,
  input  logic [LANES-1:0] lane_up_in,
  input  logic             channel_up_in,
  output logic             rx_hard_err,
  output logic             soft_err_rx,
  output logic             frame_err_rx,
  output logic             rx_channel_up,
  output logic [LANES-1:0] rx_lane_up,
  input  logic             cnt_clear,
  output logic [1:0]       link_state,
  output logic             link_stable,
  output logic [CNT_W-1:0] soft_err_cnt,
  output logic [CNT_W-1:0] frame_err_cnt,
  output logic [CNT_W-1:0] hard_err_cnt,
  output logic [CNT_W-1:0] chan_drop_cnt
);

  localparam int               c_sb_w     = 3 * LANES;
  localparam logic [3:0]       c_stretch  = 4'(STRETCH);
  localparam logic [7:0]       c_deb_last = 8'(UP_DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_DOWN     = 2'd0,
    ST_LANES_UP = 2'd1,
    ST_CHAN_UP  = 2'd2,
    ST_STABLE   = 2'd3
  } link_state_t;

  logic [c_sb_w-1:0] w_sb_in;
  logic [c_sb_w-1:0] w_sb_out;

  assign w_sb_in = {reset_in, verify_in, aligned_in};
  assign {rx_reset, rx_verify, rx_aligned} = w_sb_out;

  // Each sideband bit retriggers its own down-counter; output is counter != 0.
  generate
    for (genvar i = 0; i < c_sb_w; i++) begin : g_stretch
      logic [3:0] r_cnt;
      always_ff @(posedge user_clk_rx or negedge rx_system_reset_n) begin
        if (!rx_system_reset_n) begin
          r_cnt <= 4'd0;
        end else if (w_sb_in[i]) begin
          r_cnt <= c_stretch;
        end else if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
      assign w_sb_out[i] = (r_cnt != 4'd0);
    end
  endgenerate

  always_ff @(posedge user_clk_rx or negedge rx_system_reset_n) begin
    if (!rx_system_reset_n) begin
      rx_hard_err   <= 1'b0;
      soft_err_rx   <= 1'b0;
      frame_err_rx  <= 1'b0;
      rx_channel_up <= 1'b0;
      rx_lane_up    <= '0;
    end else begin
      rx_hard_err   <= hard_err_in;
      soft_err_rx   <= soft_err_in;
      frame_err_rx  <= frame_err_in;
      rx_channel_up <= channel_up_in;
      rx_lane_up    <= lane_up_in;
    end
  end

  link_state_t r_state;
  logic [7:0]  r_debounce;
  logic        w_lanes_up;
  logic        w_in_chan;
  logic        w_drop;

  assign link_state = r_state;
  assign w_lanes_up = &rx_lane_up;
  assign w_in_chan  = (r_state == ST_CHAN_UP) || (r_state == ST_STABLE);
  // Any exit from CHAN_UP/STABLE counts as a channel drop.
  assign w_drop     = w_in_chan && (rx_hard_err || !w_lanes_up || !rx_channel_up);

  always_ff @(posedge user_clk_rx or negedge rx_system_reset_n) begin
    if (!rx_system_reset_n) begin
      r_state     <= ST_DOWN;
      r_debounce  <= 8'd0;
      link_stable <= 1'b0;
    end else if (rx_hard_err || !w_lanes_up) begin
      r_state     <= ST_DOWN;
      link_stable <= 1'b0;
    end else if (w_in_chan && !rx_channel_up) begin
      r_state     <= ST_LANES_UP;
      link_stable <= 1'b0;
    end else begin
      case (r_state)
        ST_DOWN: begin
          r_state <= ST_LANES_UP;
        end
        ST_LANES_UP: begin
          if (rx_channel_up) begin
            r_state    <= ST_CHAN_UP;
            r_debounce <= 8'd0;
          end
        end
        ST_CHAN_UP: begin
          r_debounce <= r_debounce + 8'd1;
          if (r_debounce == c_deb_last) begin
            r_state     <= ST_STABLE;
            link_stable <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v, input logic en);
    f_sat_inc = (en && (v != c_cnt_max)) ? v + c_cnt_one : v;
  endfunction

  always_ff @(posedge user_clk_rx or negedge rx_system_reset_n) begin
    if (!rx_system_reset_n || cnt_clear) begin
      soft_err_cnt  <= '0;
      frame_err_cnt <= '0;
      hard_err_cnt  <= '0;
      chan_drop_cnt <= '0;
    end else begin
      soft_err_cnt  <= f_sat_inc(soft_err_cnt, soft_err_rx);
      frame_err_cnt <= f_sat_inc(frame_err_cnt, frame_err_rx);
      hard_err_cnt  <= f_sat_inc(hard_err_cnt, rx_hard_err);
      chan_drop_cnt <= f_sat_inc(chan_drop_cnt, w_drop);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aurora_rx_link_monitor.sv
`default_nettype none
// ============================================================================
// tb_aurora_rx_link_monitor : directed + random bench with reference model
// Revision 1.0
// ============================================================================
module tb_aurora_rx_link_monitor;
  localparam int LANES = 2, STRETCH = 4, CNT_W = 4, UP_DEBOUNCE = 8;
  localparam int SB = 3 * LANES;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic user_clk_rx = 1'b0;
  logic rx_system_reset_n;
  logic [LANES-1:0] aligned_in, verify_in, reset_in, rx_aligned, rx_verify, rx_reset;
  logic hard_err_in, soft_err_in, frame_err_in, channel_up_in, cnt_clear;
  logic [LANES-1:0] lane_up_in, rx_lane_up;
  logic rx_hard_err, soft_err_rx, frame_err_rx, rx_channel_up, link_stable;
  logic [1:0] link_state;
  logic [CNT_W-1:0] soft_err_cnt, frame_err_cnt, hard_err_cnt, chan_drop_cnt;

  always #5 user_clk_rx = ~user_clk_rx;

  aurora_rx_link_monitor #(.LANES(LANES), .STRETCH(STRETCH), .CNT_W(CNT_W),
                           .UP_DEBOUNCE(UP_DEBOUNCE)) dut (
    .user_clk_rx(user_clk_rx), .rx_system_reset_n(rx_system_reset_n),
    .aligned_in(aligned_in), .verify_in(verify_in), .reset_in(reset_in),
    .rx_aligned(rx_aligned), .rx_verify(rx_verify), .rx_reset(rx_reset),
    .hard_err_in(hard_err_in), .soft_err_in(soft_err_in), .frame_err_in(frame_err_in),
    .lane_up_in(lane_up_in), .channel_up_in(channel_up_in),
    .rx_hard_err(rx_hard_err), .soft_err_rx(soft_err_rx), .frame_err_rx(frame_err_rx),
    .rx_channel_up(rx_channel_up), .rx_lane_up(rx_lane_up), .cnt_clear(cnt_clear),
    .link_state(link_state), .link_stable(link_stable),
    .soft_err_cnt(soft_err_cnt), .frame_err_cnt(frame_err_cnt),
    .hard_err_cnt(hard_err_cnt), .chan_drop_cnt(chan_drop_cnt));

  int total = 0;
  int bad = 0;

  // Reference model: sideband "age since last high", stage-1 flag copies,
  // run lengths of good-lane cycles and channel-up cycles, plain counters.
  int age[SB];
  logic m_hard, m_soft, m_frame, m_chan;
  logic [LANES-1:0] m_lane;
  int g_run, c_run, m_state, m_soft_c, m_frame_c, m_hard_c, m_drop_c;

  function automatic int state_of(input int g, input int c);
    int cp;
    if (g == 0) return 0;
    cp = (c < g - 1) ? c : g - 1;
    if (cp == 0) return 1;
    if (cp <= UP_DEBOUNCE) return 2;
    return 3;
  endfunction

  function automatic int sat(input int v, input logic en);
    return (en && v < CMAX) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SB; i++) age[i] = 1000;
    {m_hard, m_soft, m_frame, m_chan} = 4'b0;
    m_lane = '0;
    g_run = 0; c_run = 0; m_state = 0;
    m_soft_c = 0; m_frame_c = 0; m_hard_c = 0; m_drop_c = 0;
  endtask

  task automatic model_edge();
    logic good;
    int ns;
    logic [SB-1:0] sb;
    good  = (&m_lane) && !m_hard;
    g_run = good ? g_run + 1 : 0;
    c_run = (good && m_chan) ? c_run + 1 : 0;
    ns    = state_of(g_run, c_run);
    if (cnt_clear) begin
      m_soft_c = 0; m_frame_c = 0; m_hard_c = 0; m_drop_c = 0;
    end else begin
      m_soft_c  = sat(m_soft_c, m_soft);
      m_frame_c = sat(m_frame_c, m_frame);
      m_hard_c  = sat(m_hard_c, m_hard);
      m_drop_c  = sat(m_drop_c, m_state >= 2 && ns < 2);
    end
    m_state = ns;
    m_hard = hard_err_in; m_soft = soft_err_in; m_frame = frame_err_in;
    m_chan = channel_up_in; m_lane = lane_up_in;
    sb = {reset_in, verify_in, aligned_in};
    for (int i = 0; i < SB; i++) age[i] = sb[i] ? 0 : ((age[i] < 1000) ? age[i] + 1 : 1000);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [SB-1:0] e;
    for (int i = 0; i < SB; i++) e[i] = (age[i] < STRETCH);
    chk("sideband", 32'({rx_reset, rx_verify, rx_aligned}), 32'(e));
    chk("flags", 32'({rx_hard_err, soft_err_rx, frame_err_rx, rx_channel_up}),
        32'({m_hard, m_soft, m_frame, m_chan}));
    chk("lane_up", 32'(rx_lane_up), 32'(m_lane));
    chk("link_state", 32'(link_state), 32'(m_state));
    chk("link_stable", 32'(link_stable), 32'(m_state == 3));
    chk("soft_cnt", 32'(soft_err_cnt), 32'(m_soft_c));
    chk("frame_cnt", 32'(frame_err_cnt), 32'(m_frame_c));
    chk("hard_cnt", 32'(hard_err_cnt), 32'(m_hard_c));
    chk("drop_cnt", 32'(chan_drop_cnt), 32'(m_drop_c));
  endtask

  task automatic cyc();
    @(posedge user_clk_rx);
    if (!rx_system_reset_n) model_reset(); else model_edge();
    #1 check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic zero_inputs();
    aligned_in = '0; verify_in = '0; reset_in = '0; lane_up_in = '0;
    {hard_err_in, soft_err_in, frame_err_in, channel_up_in, cnt_clear} = 5'b0;
  endtask

  initial begin
    zero_inputs();
    rx_system_reset_n = 1'b0;
    model_reset();
    idle(3);
    rx_system_reset_n = 1'b1;
    idle(2);

    // stretch with retrigger on verify[0]
    verify_in = 2'b01; cyc();
    chk("verify_rise", 32'(rx_verify), 32'h1);
    verify_in = 2'b00; cyc();
    verify_in = 2'b01; cyc();
    verify_in = 2'b00; idle(7);
    aligned_in = 2'b10; reset_in = 2'b01; cyc();
    aligned_in = 2'b00; reset_in = 2'b00; idle(5);

    // bring-up to STABLE
    lane_up_in = 2'b11; idle(3);
    channel_up_in = 1'b1; idle(12);
    chk("stable_state", 32'(link_state), 32'h3);
    chk("stable_flag", 32'(link_stable), 32'h1);

    // channel drop, then lane drop from LANES_UP
    channel_up_in = 1'b0; cyc();
    lane_up_in = 2'b01; idle(3);
    chk("drop_once", 32'(chan_drop_cnt), 32'h1);
    chk("lane_down", 32'(link_state), 32'h0);

    // hard error from STABLE
    lane_up_in = 2'b11; channel_up_in = 1'b1; idle(14);
    hard_err_in = 1'b1; cyc();
    hard_err_in = 1'b0; cyc();
    chk("hard_down", 32'(link_state), 32'h0);
    chk("hard_cnt1", 32'(hard_err_cnt), 32'h1);
    chk("hard_drop", 32'(chan_drop_cnt), 32'h2);
    idle(3);

    // saturation
    soft_err_in = 1'b1; idle(20);
    soft_err_in = 1'b0; idle(2);
    chk("soft_sat", 32'(soft_err_cnt), 32'hF);

    // clear collides with a stage-1 frame error
    frame_err_in = 1'b1; idle(3);
    frame_err_in = 1'b0; cnt_clear = 1'b1; cyc();
    cnt_clear = 1'b0; cyc();
    chk("clear_collide", 32'(frame_err_cnt), 32'h0);
    frame_err_in = 1'b1; cyc();
    frame_err_in = 1'b0; idle(2);
    chk("frame_after", 32'(frame_err_cnt), 32'h1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      aligned_in   = ($urandom_range(0, 9) == 0) ? LANES'($urandom) : '0;
      verify_in    = ($urandom_range(0, 9) == 0) ? LANES'($urandom) : '0;
      reset_in     = ($urandom_range(0, 9) == 0) ? LANES'($urandom) : '0;
      lane_up_in   = ($urandom_range(0, 59) == 0) ? LANES'($urandom) : '1;
      channel_up_in = ($urandom_range(0, 29) != 0);
      hard_err_in  = ($urandom_range(0, 79) == 0);
      soft_err_in  = ($urandom_range(0, 5) == 0);
      frame_err_in = ($urandom_range(0, 7) == 0);
      cnt_clear    = ($urandom_range(0, 49) == 0);
      cyc();
    end

    // asynchronous reset while STABLE with sidebands active
    zero_inputs();
    lane_up_in = 2'b11; channel_up_in = 1'b1; idle(14);
    aligned_in = 2'b11; verify_in = 2'b10; soft_err_in = 1'b1; idle(2);
    #2 rx_system_reset_n = 1'b0;
    #1 model_reset();
    check_all();
    zero_inputs();
    idle(2);
    rx_system_reset_n = 1'b1;
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
